// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART TX byte port among NUM_REQ packet sources.
// Define UART_ARB_ID_HDR_EN to prefix every grant with a {4'hA, grant_id} header byte.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int ID_W         = 2,
  parameter int MAX_BURST    = 16,
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_data_valid,
  output logic [7:0]           tx_data,
  input  logic                 tx_data_ready,
  output logic                 grant_active,
  output logic [ID_W-1:0]      grant_id,
  output logic                 busy
);

  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam int IDL_W = $clog2(IDLE_TIMEOUT) + 1;

`ifdef UART_ARB_ID_HDR_EN
  typedef enum logic [1:0] {S_IDLE, S_HDR, S_XFER} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_XFER} state_t;
`endif

  state_t             r_state;
  state_t             w_next;
  logic [ID_W-1:0]    r_grant_id;
  logic [ID_W-1:0]    r_last_grant;
  logic [CNT_W-1:0]   r_count;
  logic [IDL_W-1:0]   r_idle;
  logic [ID_W-1:0]    w_win;
  logic               w_sel_valid;
  logic               w_sel_last;
  logic [7:0]         w_sel_data;
  logic               w_tx_valid;
  logic [7:0]         w_tx_data;
  logic [NUM_REQ-1:0] w_ready;
  logic               w_release;

  assign w_sel_valid = req_valid[r_grant_id];
  assign w_sel_last  = req_last[r_grant_id];
  assign w_sel_data  = req_data[{r_grant_id, 3'b000} +: 8];

  // Lowest index above last_grant wins; otherwise lowest index at or below it.
  always_comb begin
    w_win = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req_valid[i] && i <= int'(r_last_grant))
        w_win = ID_W'(i);
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req_valid[i] && i > int'(r_last_grant))
        w_win = ID_W'(i);
  end

  always_comb begin
    w_next     = r_state;
    w_tx_valid = 1'b0;
    w_tx_data  = '0;
    w_ready    = '0;
    w_release  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
`ifdef UART_ARB_ID_HDR_EN
        if (|req_valid) w_next = S_HDR;
`else
        if (|req_valid) w_next = S_XFER;
`endif
      end
`ifdef UART_ARB_ID_HDR_EN
      S_HDR: begin
        w_tx_valid = 1'b1;
        w_tx_data  = {4'hA, 4'(r_grant_id)};
        if (tx_data_ready) w_next = S_XFER;
      end
`endif
      S_XFER: begin
        w_tx_valid          = w_sel_valid;
        w_tx_data           = w_sel_data;
        w_ready[r_grant_id] = tx_data_ready;
        if (w_sel_valid && tx_data_ready &&
            (w_sel_last || r_count == CNT_W'(MAX_BURST - 1)))
          w_release = 1'b1;
        if (!w_sel_valid && r_idle == IDL_W'(IDLE_TIMEOUT - 1))
          w_release = 1'b1;
        if (w_release) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_grant_id   <= '0;
      r_last_grant <= ID_W'(NUM_REQ - 1);
      r_count      <= '0;
      r_idle       <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && |req_valid)
        r_grant_id <= w_win;
      if (r_state == S_XFER) begin
        if (w_release) begin
          r_last_grant <= r_grant_id;
          r_count      <= '0;
          r_idle       <= '0;
        end else begin
          if (w_sel_valid && tx_data_ready)
            r_count <= r_count + CNT_W'(1);
          // A stall with valid high is not idle time.
          r_idle <= w_sel_valid ? '0 : r_idle + IDL_W'(1);
        end
      end
    end
  end

  assign tx_data_valid = w_tx_valid;
  assign tx_data       = w_tx_data;
  assign req_ready     = w_ready;
  assign grant_active  = (r_state != S_IDLE);
  assign grant_id      = r_grant_id;
  assign busy          = (r_state != S_IDLE) || (|req_valid);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random traffic
// checked every cycle against a transaction-level model of the arbiter.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int MB = 16;
  localparam int IT = 64;
`ifdef UART_ARB_ID_HDR_EN
  localparam bit HDR = 1'b1;
`else
  localparam bit HDR = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*8-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           tx_data_valid;
  logic [7:0]     tx_data;
  logic           tx_data_ready;
  logic           grant_active;
  logic [IW-1:0]  grant_id;
  logic           busy;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ(N), .ID_W(IW), .MAX_BURST(MB), .IDLE_TIMEOUT(IT)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready),
    .tx_data_valid(tx_data_valid), .tx_data(tx_data),
    .tx_data_ready(tx_data_ready),
    .grant_active(grant_active), .grant_id(grant_id), .busy(busy)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Model: who owns the port, who owned it last, bytes and quiet cycles in this grant.
  int m_owner, m_last, m_gid, m_cnt, m_quiet;
  bit m_hdr;

  logic          s_v, s_ga;
  logic [7:0]    s_d;
  logic [N-1:0]  s_r;
  logic [IW-1:0] s_gid;
  logic [N-1:0]  e_ready;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_last = N - 1; m_gid = 0;
    m_cnt = 0; m_quiet = 0; m_hdr = 1'b0;
  endtask

  // Called at posedge+1: apply inputs, compare at +3, advance model for the coming edge.
  task automatic step(input logic [N-1:0] v, input logic [N*8-1:0] d,
                      input logic [N-1:0] l, input logic tr);
    logic       ev, ega, ebusy, hs, rel, found;
    logic [7:0] ed;
    int         o, c;
    req_valid = v; req_data = d; req_last = l; tx_data_ready = tr;
    #2;
    o = m_owner;
    if (o < 0) begin
      ev = 0; ed = 0; e_ready = '0; ega = 0;
    end else if (m_hdr) begin
      ev = 1; ed = 8'hA0 | 8'(o); e_ready = '0; ega = 1;
    end else begin
      ev = v[o]; ed = d[8*o +: 8]; ega = 1;
      e_ready = tr ? (N'(1) << o) : '0;
    end
    ebusy = (o >= 0) || (|v);
    s_v = tx_data_valid; s_d = tx_data; s_r = req_ready;
    s_ga = grant_active; s_gid = grant_id;
    chk("tx_valid", s_v, ev);
    chk("tx_data", s_d, ed);
    chk("req_ready", s_r, e_ready);
    chk("grant_active", s_ga, ega);
    chk("grant_id", s_gid, m_gid);
    chk("busy", busy, ebusy);
    if (o < 0) begin
      found = 0;
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (!found && v[c]) begin
          found = 1; m_owner = c; m_gid = c;
          m_cnt = 0; m_quiet = 0; m_hdr = HDR;
        end
      end
    end else if (m_hdr) begin
      if (tr) m_hdr = 0;
    end else begin
      hs  = v[o] && tr;
      rel = (hs && (l[o] || m_cnt + 1 == MB)) || (!v[o] && m_quiet + 1 == IT);
      if (rel) begin
        m_last = o; m_owner = -1;
      end else begin
        if (hs) m_cnt++;
        m_quiet = v[o] ? 0 : m_quiet + 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0; req_data = '0; req_last = '0; tx_data_ready = 1'b0;
    #2;
    chk("rst_tx_valid", tx_data_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_grant", grant_active, 0);
    chk("rst_gid", grant_id, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  logic [7:0]    sd[N];
  logic          sl[N];
  int            srem[N];
  logic [N-1:0]  rv, rl;
  logic [N*8-1:0] rd;
  int            gq[$];
  logic [7:0]    dq[$];
  int            low, lead;
  logic [7:0]    b2;

  initial begin
    reset = 1'b1;
    req_valid = '0; req_data = '0; req_last = '0; tx_data_ready = 1'b0;
    model_reset();
    @(posedge clk);
    #1;

    // Single 3-byte packet from requester 0.
    do_reset();
    step(4'b0001, 32'h11, 4'b0000, 1'b1);
    chk("t1_latency", s_ga, 0);
`ifdef UART_ARB_ID_HDR_EN
    step(4'b0001, 32'h11, 4'b0000, 1'b1);
    chk("t1_hdr", s_d, 8'hA0);
`endif
    step(4'b0001, 32'h11, 4'b0000, 1'b1);
    chk("t1_grant", s_ga, 1);
    chk("t1_gid", s_gid, 0);
    chk("t1_b0", s_d, 8'h11);
    step(4'b0001, 32'h22, 4'b0000, 1'b1);
    chk("t1_b1", s_d, 8'h22);
    step(4'b0001, 32'h33, 4'b0001, 1'b1);
    chk("t1_b2", s_d, 8'h33);
    step(4'b0000, 32'h0, 4'b0000, 1'b1);
    chk("t1_idle", s_ga, 0);
`ifdef UART_ARB_ID_HDR_EN
    step(4'b1000, 32'h55000000, 4'b1000, 1'b1);
    step(4'b1000, 32'h55000000, 4'b1000, 1'b1);
    chk("hdr_byte", s_d, 8'hA3);
    chk("hdr_ready", s_r, 4'b0000);
    step(4'b1000, 32'h55000000, 4'b1000, 1'b1);
    chk("hdr_payload", s_d, 8'h55);
    chk("hdr_payload_rdy", s_r, 4'b1000);
    step(4'b0000, 32'h0, 4'b0000, 1'b1);
`endif

    // All four requesters with 1-byte packets.
    do_reset();
    gq.delete();
    for (int c = 0; c < 16; c++) begin
      step(4'b1111, 32'h44332211, 4'b1111, 1'b1);
      if (s_v && s_r != '0) gq.push_back(int'(s_gid));
    end
    chk("t2_n", gq.size() >= 5, 1);
    if (gq.size() >= 5) begin
      chk("t2_g0", gq[0], 0);
      chk("t2_g1", gq[1], 1);
      chk("t2_g2", gq[2], 2);
      chk("t2_g3", gq[3], 3);
      chk("t2_g4", gq[4], 0);
    end

    // Requester 2 streams without last; requester 3 pending.
    do_reset();
    gq.delete(); dq.delete();
    b2 = 8'd0;
    for (int c = 0; c < 60; c++) begin
      step(4'b1100, {8'h3C, b2, 16'h0}, 4'b1000, 1'b1);
      if (s_v && s_r != '0) begin
        gq.push_back(int'(s_gid)); dq.push_back(s_d);
      end
      if (e_ready[2]) b2++;
    end
    lead = 0;
    while (lead < gq.size() && gq[lead] == 2) lead++;
    chk("t3_burst", lead, 16);
    chk("t3_next", lead + 1 < gq.size(), 1);
    if (lead + 1 < gq.size()) begin
      chk("t3_gid3", gq[lead], 3);
      chk("t3_resume_gid", gq[lead+1], 2);
      chk("t3_resume_byte", dq[lead+1], 8'd16);
    end

    // Stall does not revoke; quiet valid does after IT cycles.
    do_reset();
    for (int c = 0; c < 12; c++)
      step(4'b0010, 32'h0000AB00, 4'b0000, 1'b0);
    chk("t4_stall_hold", s_ga, 1);
    step(4'b0010, 32'h0000AB00, 4'b0000, 1'b1);
    step(4'b0010, 32'h0000AC00, 4'b0000, 1'b1);
    low = 0;
    for (int c = 0; c < 200; c++) begin
      step(4'b0000, 32'h0, 4'b0000, 1'b1);
      if (!s_ga) break;
      low++;
    end
    chk("t4_timeout", low, IT);

    // Async reset mid-packet.
    do_reset();
    for (int c = 0; c < 4; c++)
      step(4'b0010, 32'h00005A00, 4'b0000, 1'b1);
    reset = 1'b1;
    #1;
    chk("t5_valid", tx_data_valid, 0);
    chk("t5_data", tx_data, 0);
    chk("t5_ready", req_ready, 0);
    chk("t5_grant", grant_active, 0);
    chk("t5_gid", grant_id, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    step(4'b1111, 32'h44332211, 4'b1111, 1'b1);
    step(4'b1111, 32'h44332211, 4'b1111, 1'b1);
    chk("t5_restart_gid", s_gid, 0);
    chk("t5_restart_act", s_ga, 1);

    // Random traffic in three load profiles.
    do_reset();
    for (int i = 0; i < N; i++) begin
      srem[i] = $urandom_range(24, 1);
      sd[i] = 8'($urandom);
      sl[i] = (srem[i] == 1);
    end
    for (int ph = 0; ph < 3; ph++) begin
      int pv, pt;
      pv = (ph == 0) ? 70 : (ph == 1) ? 3 : 95;
      pt = (ph == 0) ? 70 : (ph == 1) ? 90 : 50;
      for (int c = 0; c < 1500; c++) begin
        for (int i = 0; i < N; i++) begin
          rv[i] = ($urandom_range(99) < pv);
          rd[8*i +: 8] = sd[i];
          rl[i] = sl[i];
        end
        step(rv, rd, rl, $urandom_range(99) < pt);
        for (int i = 0; i < N; i++) begin
          if (e_ready[i] && rv[i]) begin
            srem[i]--;
            if (srem[i] == 0) srem[i] = $urandom_range(24, 1);
            sd[i] = 8'($urandom);
            sl[i] = (srem[i] == 1);
          end
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
